// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared state type and latency constant for the spike count classifier
// Purpose: common definitions imported by spike_count_classifier and max2_tracker.
// Contents: cls_state_t (IDLE/SCAN/DRAIN/DONE), classifier_latency(), CLASSIFIER_LATENCY.
package snn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } cls_state_t;

   localparam int DEFAULT_NUM_OUTPUTS = 10;

   // One cycle per address, one for the RAM read stage, one for the drain compare.
   function automatic int classifier_latency(input int num_outputs);
      return num_outputs + 2;
   endfunction

   localparam int CLASSIFIER_LATENCY = classifier_latency(DEFAULT_NUM_OUTPUTS);

endpackage

// File: rtl/max2_tracker.sv
// rtl/max2_tracker.sv - running largest / second-largest tracker with lowest-index tie resolution
// Purpose: folds one count word per update into max, second, index-of-max and tie flag.
// Ports: clk, rst (sync, active high), clear (zero all state), update (fold data in),
//        data/data_idx (word and its index), max_val, second_val, max_idx, tie.
module max2_tracker
   import snn_pkg::*;
#(
   parameter int COUNT_WIDTH = 32,
   parameter int IDX_WIDTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   update,
   input  logic [COUNT_WIDTH-1:0] data,
   input  logic [IDX_WIDTH-1:0]   data_idx,
   output logic [COUNT_WIDTH-1:0] max_val,
   output logic [COUNT_WIDTH-1:0] second_val,
   output logic [IDX_WIDTH-1:0]   max_idx,
   output logic                   tie
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         max_val    <= '0;
         second_val <= '0;
         max_idx    <= '0;
         tie        <= 1'b0;
      end else if (update) begin
         if (data_idx == '0) begin
            // First word seeds the running max; there is no second yet.
            max_val    <= data;
            max_idx    <= '0;
            second_val <= '0;
            tie        <= 1'b0;
         end else if (data > max_val) begin
            second_val <= max_val;
            max_val    <= data;
            max_idx    <= data_idx;
            tie        <= 1'b0;
         end else if (data == max_val) begin
            // Equal to max: keep the earlier (lower) index, record the duplicate.
            second_val <= data;
            tie        <= 1'b1;
         end else if (data > second_val) begin
            second_val <= data;
         end
      end
   end

endmodule

// File: rtl/spike_count_classifier.sv
// rtl/spike_count_classifier.sv - scans output spike counts and reports the winning class
// Purpose: reads NUM_OUTPUTS count words from a 1-cycle-latency RAM and reports argmax,
//          max, second-largest, margin and tie, holding results between scans.
// Ports: clk, rst (sync, active high), start; cnt_rd_en/cnt_rd_addr/cnt_rd_data (count RAM);
//        busy, done, class_idx, max_count, second_count, margin, tie, result_valid.
module spike_count_classifier
   import snn_pkg::*;
#(
   parameter int NUM_OUTPUTS = 10,
   parameter int COUNT_WIDTH = 32,
   parameter int IDX_WIDTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   cnt_rd_en,
   output logic [IDX_WIDTH-1:0]   cnt_rd_addr,
   input  logic [COUNT_WIDTH-1:0] cnt_rd_data,
   output logic                   busy,
   output logic                   done,
   output logic [IDX_WIDTH-1:0]   class_idx,
   output logic [COUNT_WIDTH-1:0] max_count,
   output logic [COUNT_WIDTH-1:0] second_count,
   output logic [COUNT_WIDTH-1:0] margin,
   output logic                   tie,
   output logic                   result_valid
);

   localparam logic [IDX_WIDTH-1:0] LAST_ADDR = IDX_WIDTH'(NUM_OUTPUTS - 1);

   cls_state_t state, state_nxt;
   logic                   accept;
   logic [IDX_WIDTH-1:0]   addr;
   logic                   rd_pend;    // cnt_rd_data carries a requested word this cycle
   logic [IDX_WIDTH-1:0]   pend_idx;   // index of that word
   logic [COUNT_WIDTH-1:0] trk_max, trk_second;
   logic [IDX_WIDTH-1:0]   trk_idx;
   logic                   trk_tie;
   logic [COUNT_WIDTH-1:0] res_max, res_second;
   logic [IDX_WIDTH-1:0]   res_idx;
   logic                   res_tie;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      cnt_rd_en = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_SCAN;
            end
         end
         ST_SCAN: begin
            cnt_rd_en = 1'b1;
            busy      = 1'b1;
            if (addr == LAST_ADDR) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy      = 1'b1;
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr         <= '0;
         rd_pend      <= 1'b0;
         pend_idx     <= '0;
         result_valid <= 1'b0;
         res_max      <= '0;
         res_second   <= '0;
         res_idx      <= '0;
         res_tie      <= 1'b0;
      end else begin
         rd_pend  <= cnt_rd_en;
         pend_idx <= addr;
         if (accept) begin
            addr         <= '0;
            result_valid <= 1'b0;
         end else if (state == ST_SCAN) begin
            addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
         end
         if (state == ST_DRAIN) result_valid <= 1'b1;
         // Tracker is cleared by the next start, so keep a copy for the idle period.
         if (done) begin
            res_max    <= trk_max;
            res_second <= trk_second;
            res_idx    <= trk_idx;
            res_tie    <= trk_tie;
         end
      end
   end

   max2_tracker #(
      .COUNT_WIDTH(COUNT_WIDTH),
      .IDX_WIDTH  (IDX_WIDTH)
   ) u_tracker (
      .clk       (clk),
      .rst       (rst),
      .clear     (accept),
      .update    (rd_pend),
      .data      (cnt_rd_data),
      .data_idx  (pend_idx),
      .max_val   (trk_max),
      .second_val(trk_second),
      .max_idx   (trk_idx),
      .tie       (trk_tie)
   );

   assign cnt_rd_addr = addr;

   // During DONE the tracker already holds the final values; afterwards the copy does.
   assign class_idx    = done ? trk_idx    : res_idx;
   assign max_count    = done ? trk_max    : res_max;
   assign second_count = done ? trk_second : res_second;
   assign tie          = done ? trk_tie    : res_tie;
   assign margin       = max_count - second_count;

endmodule

// File: tb/tb_spike_count_classifier.sv
// tb/tb_spike_count_classifier.sv - self-checking bench for spike_count_classifier
module tb_spike_count_classifier;

   localparam int N  = 10;
   localparam int CW = 32;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          cnt_rd_en;
   logic [IW-1:0] cnt_rd_addr;
   logic [CW-1:0] cnt_rd_data = '0;
   logic          busy, done, tie, result_valid;
   logic [IW-1:0] class_idx;
   logic [CW-1:0] max_count, second_count, margin;

   logic [CW-1:0] mem [N];

   int checks = 0;
   int errors = 0;
   logic [CW-1:0] prev_max = '0;
   logic [IW-1:0] prev_idx = '0;

   always #5 clk = ~clk;

   // Count RAM: data for an address appears one cycle after it is presented.
   always @(posedge clk) if (cnt_rd_en) cnt_rd_data <= mem[cnt_rd_addr];

   spike_count_classifier #(.NUM_OUTPUTS(N), .COUNT_WIDTH(CW), .IDX_WIDTH(IW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cnt_rd_en(cnt_rd_en), .cnt_rd_addr(cnt_rd_addr), .cnt_rd_data(cnt_rd_data),
      .busy(busy), .done(done), .class_idx(class_idx), .max_count(max_count),
      .second_count(second_count), .margin(margin), .tie(tie), .result_valid(result_valid)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: sort the counts; max is the top, second is the next entry (duplicates kept).
   task automatic model(output logic [IW-1:0] e_idx, output logic [CW-1:0] e_max,
                        output logic [CW-1:0] e_sec, output logic e_tie);
      int unsigned q[$];
      for (int i = 0; i < N; i++) q.push_back(mem[i]);
      q.rsort();
      e_max = q[0];
      e_sec = (N > 1) ? q[1] : 0;
      e_tie = (N > 1) && (q[1] == q[0]);
      e_idx = '0;
      for (int i = N - 1; i >= 0; i--) if (mem[i] == e_max) e_idx = IW'(i);
   endtask

   task automatic chk_results(input string name);
      logic [IW-1:0] e_idx;
      logic [CW-1:0] e_max, e_sec;
      logic          e_tie;
      model(e_idx, e_max, e_sec, e_tie);
      chk({name, "_idx"},    class_idx,    e_idx);
      chk({name, "_max"},    max_count,    e_max);
      chk({name, "_second"}, second_count, e_sec);
      chk({name, "_margin"}, margin,       e_max - e_sec);
      chk({name, "_tie"},    tie,          e_tie);
      prev_max = e_max;
      prev_idx = e_idx;
   endtask

   task automatic run_scan(input string name);
      int reads = 0;
      bit seen = 0;
      @(negedge clk) start = 1'b1;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (c == 0) begin
            start = 1'b0;
            chk({name, "_rv_cleared"}, result_valid, 0);
            chk({name, "_busy"}, busy, 1);
         end
         if (c == 3) begin
            chk({name, "_hold_max"}, max_count, prev_max);
            chk({name, "_hold_idx"}, class_idx, prev_idx);
         end
         if (cnt_rd_en) begin
            chk({name, "_addr"}, cnt_rd_addr, reads);
            reads++;
         end
         if (done) begin
            seen = 1;
            chk({name, "_latency"}, c + 1, N + 2);
            chk({name, "_reads"}, reads, N);
            chk({name, "_rv"}, result_valid, 1);
            chk_results(name);
         end
      end
      if (!seen) chk({name, "_done_timeout"}, 0, 1);
      @(negedge clk);
      chk({name, "_done_pulse"}, done, 0);
      chk({name, "_idle"}, busy, 0);
      chk({name, "_kept_max"}, max_count, prev_max);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      for (int i = 0; i < N; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rv", result_valid, 0);
      chk("rst_en", cnt_rd_en, 0);
      chk("rst_addr", cnt_rd_addr, 0);
      chk("rst_max", max_count, 0);
      chk("rst_tie", tie, 0);
      rst = 1'b0;

      begin
         int v[N] = '{3, 9, 1, 4, 0, 2, 7, 5, 8, 6};
         for (int i = 0; i < N; i++) mem[i] = v[i];
      end
      run_scan("vec_a");
      chk("vec_a_idx_const", class_idx, 1);
      chk("vec_a_margin_const", margin, 1);

      for (int i = 0; i < N; i++) mem[i] = '0;
      mem[0] = 5; mem[1] = 2; mem[2] = 9; mem[3] = 9;
      run_scan("vec_tie");
      chk("vec_tie_const", tie, 1);

      for (int i = 0; i < N; i++) mem[i] = '0;
      run_scan("all_zero");

      mem[9] = 32'hFFFF_FFFF;
      run_scan("top_last");
      chk("top_last_margin_const", margin, 32'hFFFF_FFFF);

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < N; i++)
            mem[i] = (t % 2 == 1) ? $urandom_range(0, 7) : $urandom;
         run_scan($sformatf("rand%0d", t));
      end

      // Reset in the middle of a scan.
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      begin
         bit hit = 0;
         for (int c = 0; c < 20 && !hit; c++) begin
            if (cnt_rd_en && cnt_rd_addr == 5) hit = 1;
            else @(negedge clk);
         end
         if (!hit) chk("midrst_addr5_timeout", 0, 1);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_en", cnt_rd_en, 0);
      chk("midrst_addr", cnt_rd_addr, 0);
      chk("midrst_rv", result_valid, 0);
      chk("midrst_max", max_count, 0);
      chk("midrst_second", second_count, 0);
      chk("midrst_idx", class_idx, 0);
      chk("midrst_tie", tie, 0);
      rst = 1'b0;
      prev_max = '0;
      prev_idx = '0;
      for (int i = 0; i < N; i++) mem[i] = $urandom_range(0, 1000);
      run_scan("after_rst");

      // Start held high: back-to-back scans.
      for (int i = 0; i < N; i++) mem[i] = $urandom_range(0, 15);
      begin
         int last_done = -1;
         int ndone = 0;
         logic prev_busy = busy;
         bit idle = 0;
         @(negedge clk) start = 1'b1;
         for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (busy && !prev_busy) chk("held_rv_drop", result_valid, 0);
            if (done) begin
               if (last_done >= 0) chk("held_period", c - last_done, N + 3);
               last_done = c;
               ndone++;
               chk_results("held");
            end
            prev_busy = busy;
         end
         start = 1'b0;
         chk("held_done_count", ndone, 2);
         for (int c = 0; c < 30 && !idle; c++) begin
            @(negedge clk);
            if (!busy) idle = 1;
         end
         chk("held_returns_idle", idle, 1);
         chk("held_final_rv", result_valid, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spike_count_classifier.md
SPIKE_COUNT_CLASSIFIER -- requirements
Module: spike_count_classifier

Interface
REQ-001 Parameters: NUM_OUTPUTS, default 10, number of output-neuron spike counts to scan; COUNT_WIDTH, default 32, width of one count word; IDX_WIDTH, default 4, address/index width, SHALL satisfy 2**IDX_WIDTH >= NUM_OUTPUTS.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  level-sampled request to classify; accepted only in IDLE.
REQ-005 cnt_rd_en  output  1  read strobe to the output spike count RAM.
REQ-006 cnt_rd_addr  output  IDX_WIDTH  count RAM word address.
REQ-007 cnt_rd_data  input  COUNT_WIDTH  count RAM read data, valid exactly one cycle after the address is presented.
REQ-008 busy  output  1  high in SCAN, DRAIN and DONE.
REQ-009 done  output  1  one-cycle pulse when results update.
REQ-010 class_idx  output  IDX_WIDTH  index of the largest count.
REQ-011 max_count  output  COUNT_WIDTH  largest count.
REQ-012 second_count  output  COUNT_WIDTH  second-largest count, duplicates included.
REQ-013 margin  output  COUNT_WIDTH  max_count minus second_count.
REQ-014 tie  output  1  high when at least two indices share max_count.
REQ-015 result_valid  output  1  sticky; high from done until the next accepted start or rst.

Function
REQ-016 FSM states: IDLE, SCAN, DRAIN, DONE; no other states reachable.
REQ-017 IDLE, start=1 at edge E0: go to SCAN; cnt_rd_addr=0; cnt_rd_en=1; result_valid=0; running max, second and index cleared to 0.
REQ-018 SCAN presents addresses 0..NUM_OUTPUTS-1 on consecutive cycles, one per cycle, with cnt_rd_en=1.
REQ-019 Each edge in SCAN (except the first) and the DRAIN edge compare the arriving cnt_rd_data against the running max; a one-bit pipeline flag tracks data validity.
REQ-020 Compare: data > max, then second<=max, max<=data, idx<=addr of data, tie<=0; data == max (index > 0), then second<=data, tie<=1; data < max and data > second, then second<=data.
REQ-021 The first word (index 0) loads max directly; ties resolve to the lowest index.
REQ-022 SCAN with address NUM_OUTPUTS-1 presented: next state DRAIN; DRAIN cnt_rd_en=0; DRAIN compares the last word, then goes to DONE.
REQ-023 DONE lasts one cycle: done=1; class_idx, max_count, second_count, margin and tie registered and stable; result_valid=1; next state IDLE.
REQ-024 Latency: done high in the cycle after edge E(NUM_OUTPUTS+1), i.e. NUM_OUTPUTS+2 cycles after start is sampled.
REQ-025 start in SCAN, DRAIN or DONE is ignored, not queued; start held high re-triggers from IDLE on the next cycle.
REQ-026 margin uses unsigned arithmetic; it cannot underflow because second_count <= max_count.
REQ-027 NUM_OUTPUTS=1: second_count=0, margin=max_count, tie=0.
REQ-028 All counts zero: class_idx=0, max_count=0, second_count=0, margin=0, tie=1 (NUM_OUTPUTS>1).
REQ-029 Result outputs hold their values between scans; a new scan changes them only at its DONE.

Reset
REQ-030 rst=1 in any state, including mid-scan, SHALL force IDLE and zero every output and internal register at the next edge; rst overrides start.

Structure
REQ-031 The state enum and a CLASSIFIER_LATENCY constant (NUM_OUTPUTS+2, expressed as a function) SHALL live in the shared snn package.
REQ-032 The comparator/update logic SHALL be one sub-module, max2_tracker, holding max, second, index and tie with load/update controls; the FSM and address counter stay in the top.

Verification
REQ-033 Counts {3,9,1,4,0,2,7,5,8,6}, start pulse -> done at cycle 12; class_idx=1, max=9, second=8, margin=1, tie=0.
REQ-034 Counts {5,2,9,9,0,...,0} -> class_idx=2, max=9, second=9, margin=0, tie=1.
REQ-035 All counts 0 -> class_idx=0, margin=0, tie=1; cnt_rd_addr sequence 0..9 with no gaps.
REQ-036 rst asserted at SCAN address 5 -> next cycle IDLE, busy=0, all outputs 0; a fresh start yields a correct result.
REQ-037 start held high for 30 cycles -> back-to-back scans, done every 13 cycles, start ignored while busy; result_valid drops on each accepted start.
REQ-038 Count 0xFFFFFFFF at index 9, others 0 -> class_idx=9, margin=0xFFFFFFFF, second=0.
